// File: rtl/ecap5_dproc_pkg.sv
// Shared types for the data-processor core slice: bus arbiter FSM state and owner.
package ecap5_dproc_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_REQ, ARB_WAIT, ARB_DONE} arb_state_t;
  typedef enum logic {OWNER_IF, OWNER_LS} arb_owner_t;

  localparam logic [3:0] SEL_WORD = 4'hF;

endpackage

// File: rtl/bus_arbiter.sv
// Shares one pipelined Wishbone master port between instruction fetch and load-store,
// with load-store priority bounded by a streak counter and a watchdog on hung cycles.
module bus_arbiter
  import ecap5_dproc_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned LS_STREAK_MAX  = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_ack_o,
  output logic        if_err_o,
  output logic [31:0] if_rdata_o,
  input  logic        ls_req_i,
  input  logic [31:0] ls_addr_i,
  input  logic        ls_we_i,
  input  logic [3:0]  ls_sel_i,
  input  logic [31:0] ls_wdata_i,
  output logic        ls_ack_o,
  output logic        ls_err_o,
  output logic [31:0] ls_rdata_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_stall_i
);

  localparam int unsigned WDW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned SW  = $clog2(LS_STREAK_MAX + 1);
  localparam logic [WDW-1:0] WD_LIMIT     = WDW'(TIMEOUT_CYCLES);
  localparam logic [SW-1:0]  STREAK_LIMIT = SW'(LS_STREAK_MAX);

  arb_state_t state_q, state_d;
  arb_owner_t owner_q, owner_d;
  logic [SW-1:0]  streak_q, streak_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic        wb_cyc_q, wb_cyc_d, wb_stb_q, wb_stb_d, wb_we_q, wb_we_d;
  logic [31:0] wb_adr_q, wb_adr_d, wb_dat_q, wb_dat_d;
  logic [3:0]  wb_sel_q, wb_sel_d;
  logic        if_ack_q, if_ack_d, if_err_q, if_err_d;
  logic        ls_ack_q, ls_ack_d, ls_err_q, ls_err_d;
  logic [31:0] if_rdata_q, if_rdata_d, ls_rdata_q, ls_rdata_d;
  logic        finish, timeout;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    streak_d   = streak_q;
    wd_d       = wd_q;
    wb_cyc_d   = wb_cyc_q;
    wb_stb_d   = wb_stb_q;
    wb_we_d    = wb_we_q;
    wb_adr_d   = wb_adr_q;
    wb_sel_d   = wb_sel_q;
    wb_dat_d   = wb_dat_q;
    if_ack_d   = 1'b0;
    if_err_d   = 1'b0;
    if_rdata_d = '0;
    ls_ack_d   = 1'b0;
    ls_err_d   = 1'b0;
    ls_rdata_d = '0;
    finish     = 1'b0;
    timeout    = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        wd_d = '0;
        // Fetch only overrides load-store once the streak has saturated.
        if (ls_req_i && !(if_req_i && streak_q == STREAK_LIMIT)) begin
          owner_d  = OWNER_LS;
          wb_adr_d = ls_addr_i;
          wb_we_d  = ls_we_i;
          wb_sel_d = ls_sel_i;
          wb_dat_d = ls_wdata_i;
          wb_cyc_d = 1'b1;
          wb_stb_d = 1'b1;
          state_d  = ARB_REQ;
          if (!if_req_i)
            streak_d = '0;
          else if (streak_q != STREAK_LIMIT)
            streak_d = streak_q + 1'b1;
        end else if (if_req_i) begin
          owner_d  = OWNER_IF;
          wb_adr_d = if_addr_i;
          wb_we_d  = 1'b0;
          wb_sel_d = SEL_WORD;
          wb_dat_d = '0;
          wb_cyc_d = 1'b1;
          wb_stb_d = 1'b1;
          state_d  = ARB_REQ;
          streak_d = '0;
        end
      end
      ARB_REQ: begin
        wd_d = wd_q + 1'b1;
        if (wd_q == WD_LIMIT) begin
          timeout = 1'b1;
        end else if (!wb_stall_i) begin
          wb_stb_d = 1'b0;
          if (wb_ack_i) finish = 1'b1;
          else          state_d = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        wd_d = wd_q + 1'b1;
        if (wd_q == WD_LIMIT) timeout = 1'b1;
        else if (wb_ack_i)    finish  = 1'b1;
      end
      ARB_DONE: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase

    if (finish || timeout) begin
      state_d  = ARB_DONE;
      wb_cyc_d = 1'b0;
      wb_stb_d = 1'b0;
      if (owner_q == OWNER_LS) begin
        ls_ack_d   = 1'b1;
        ls_err_d   = timeout;
        ls_rdata_d = timeout ? '0 : wb_dat_i;
      end else begin
        if_ack_d   = 1'b1;
        if_err_d   = timeout;
        if_rdata_d = timeout ? '0 : wb_dat_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ARB_IDLE;
      owner_q    <= OWNER_IF;
      streak_q   <= '0;
      wd_q       <= '0;
      wb_cyc_q   <= 1'b0;
      wb_stb_q   <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_adr_q   <= '0;
      wb_sel_q   <= '0;
      wb_dat_q   <= '0;
      if_ack_q   <= 1'b0;
      if_err_q   <= 1'b0;
      if_rdata_q <= '0;
      ls_ack_q   <= 1'b0;
      ls_err_q   <= 1'b0;
      ls_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      streak_q   <= streak_d;
      wd_q       <= wd_d;
      wb_cyc_q   <= wb_cyc_d;
      wb_stb_q   <= wb_stb_d;
      wb_we_q    <= wb_we_d;
      wb_adr_q   <= wb_adr_d;
      wb_sel_q   <= wb_sel_d;
      wb_dat_q   <= wb_dat_d;
      if_ack_q   <= if_ack_d;
      if_err_q   <= if_err_d;
      if_rdata_q <= if_rdata_d;
      ls_ack_q   <= ls_ack_d;
      ls_err_q   <= ls_err_d;
      ls_rdata_q <= ls_rdata_d;
    end
  end

  assign wb_cyc_o   = wb_cyc_q;
  assign wb_stb_o   = wb_stb_q;
  assign wb_we_o    = wb_we_q;
  assign wb_adr_o   = wb_adr_q;
  assign wb_sel_o   = wb_sel_q;
  assign wb_dat_o   = wb_dat_q;
  assign if_ack_o   = if_ack_q;
  assign if_err_o   = if_err_q;
  assign if_rdata_o = if_rdata_q;
  assign ls_ack_o   = ls_ack_q;
  assign ls_err_o   = ls_err_q;
  assign ls_rdata_o = ls_rdata_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: each request pushes its expected completion
// (owner, data, error, cycle); a monitor pops and compares on every ack pulse.
module tb_bus_arbiter;

  localparam logic [31:0] JUNK = 32'h5A5A_5A5A;

  typedef struct {
    logic        owner_ls;
    logic [31:0] rdata;
    logic        err;
    int          cycle;
  } exp_t;

  logic        clk = 1'b0, rst = 1'b1;
  logic        if_req = 1'b0, ls_req = 1'b0, ls_we = 1'b0;
  logic [31:0] if_addr = '0, ls_addr = '0, ls_wdata = '0;
  logic [3:0]  ls_sel = '0;
  logic [31:0] wb_dat_i = JUNK;
  logic        wb_ack_i = 1'b0, wb_stall_i = 1'b0;
  logic        if_ack_o, if_err_o, ls_ack_o, ls_err_o;
  logic [31:0] if_rdata_o, ls_rdata_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [138:0] outs;

  int   passed = 0, total = 0, cyc_cnt = 0;
  exp_t sb[$];

  bus_arbiter #(.TIMEOUT_CYCLES(8), .LS_STREAK_MAX(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(if_req), .if_addr_i(if_addr),
    .if_ack_o(if_ack_o), .if_err_o(if_err_o), .if_rdata_o(if_rdata_o),
    .ls_req_i(ls_req), .ls_addr_i(ls_addr), .ls_we_i(ls_we), .ls_sel_i(ls_sel),
    .ls_wdata_i(ls_wdata),
    .ls_ack_o(ls_ack_o), .ls_err_o(ls_err_o), .ls_rdata_o(ls_rdata_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_stall_i(wb_stall_i)
  );

  assign outs = {if_ack_o, if_err_o, if_rdata_o, ls_ack_o, ls_err_o, ls_rdata_o,
                 wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o};

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  function automatic exp_t mk_exp(input logic ls, input logic [31:0] d, input logic e, input int c);
    exp_t x;
    x.owner_ls = ls;
    x.rdata    = d;
    x.err      = e;
    x.cycle    = c;
    return x;
  endfunction

  task automatic monitor();
    exp_t e;
    logic [31:0] got_d, other_d;
    logic got_e, other_e;
    forever begin
      @(negedge clk);
      if (if_ack_o || ls_ack_o) begin
        total++;
        if (sb.size() == 0) begin
          $display("FAIL unexpected_ack: if_ack=%b ls_ack=%b at cycle %0d, none expected", if_ack_o, ls_ack_o, cyc_cnt);
        end else begin
          passed++;
          e = sb.pop_front();
          got_d   = e.owner_ls ? ls_rdata_o : if_rdata_o;
          got_e   = e.owner_ls ? ls_err_o   : if_err_o;
          other_d = e.owner_ls ? if_rdata_o : ls_rdata_o;
          other_e = e.owner_ls ? if_err_o   : ls_err_o;
          total++;
          if ({if_ack_o, ls_ack_o} !== {!e.owner_ls, e.owner_ls})
            $display("FAIL ack_owner: {if,ls}=%b%b required %b%b", if_ack_o, ls_ack_o, !e.owner_ls, e.owner_ls);
          else passed++;
          total++;
          if (got_d !== e.rdata) $display("FAIL rdata: got %h required %h", got_d, e.rdata);
          else passed++;
          total++;
          if (got_e !== e.err) $display("FAIL err: got %b required %b", got_e, e.err);
          else passed++;
          total++;
          if (cyc_cnt !== e.cycle) $display("FAIL ack_cycle: got %0d required %0d", cyc_cnt, e.cycle);
          else passed++;
          total++;
          if ({other_d, other_e} !== 33'd0) $display("FAIL other_quiet: rdata=%h err=%b required 0", other_d, other_e);
          else passed++;
        end
      end else begin
        total++;
        if ({if_rdata_o, if_err_o, ls_rdata_o, ls_err_o} !== 66'd0)
          $display("FAIL idle_outputs: if %h/%b ls %h/%b required 0", if_rdata_o, if_err_o, ls_rdata_o, ls_err_o);
        else passed++;
      end
    end
  endtask

  // Slave side of one transaction: stall, accept, then ack (or never ack).
  task automatic serve(input int stall_n, input int ack_lat, input logic [31:0] data, input bit do_ack,
                       output int stb_cyc, output logic [31:0] adr, output logic we,
                       output logic [3:0] sel, output logic [31:0] dat, output bit held);
    int k;
    held = 1'b1; stb_cyc = -1; adr = '0; we = 1'b0; sel = '0; dat = '0;
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      if (wb_cyc_o && wb_stb_o) break;
    end
    if (k == 40) return;
    stb_cyc = cyc_cnt; adr = wb_adr_o; we = wb_we_o; sel = wb_sel_o; dat = wb_dat_o;
    for (int i = 0; i < stall_n; i++) begin
      wb_stall_i = 1'b1;
      @(negedge clk);
      if (!wb_stb_o || wb_adr_o !== adr || wb_dat_o !== dat) held = 1'b0;
    end
    wb_stall_i = 1'b0;
    if (!do_ack) return;
    if (ack_lat > 0) repeat (ack_lat) @(negedge clk);
    wb_ack_i = 1'b1; wb_dat_i = data;
    @(negedge clk);
    wb_ack_i = 1'b0; wb_dat_i = JUNK;
  endtask

  task automatic wait_if(output logic cyc_at_ack);
    cyc_at_ack = 1'bx;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (if_ack_o) begin cyc_at_ack = wb_cyc_o; break; end
    end
    if_req = 1'b0;
  endtask

  task automatic wait_ls(output logic cyc_at_ack);
    cyc_at_ack = 1'bx;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (ls_ack_o) begin cyc_at_ack = wb_cyc_o; break; end
    end
    ls_req = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++;
    if (outs !== '0) $display("FAIL reset_outputs: got %h required 0", outs);
    else passed++;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (outs !== '0) $display("FAIL post_reset_idle: got %h required 0", outs);
    else passed++;
  endtask

  task automatic test_single_fetch();
    int c, sc; logic [31:0] a, d; logic w, cy; logic [3:0] s; bit h;
    @(negedge clk);
    c = cyc_cnt; if_req = 1'b1; if_addr = 32'h0000_0100;
    sb.push_back(mk_exp(1'b0, 32'hDEAD_BEEF, 1'b0, c + 3));
    fork
      serve(0, 1, 32'hDEAD_BEEF, 1'b1, sc, a, w, s, d, h);
      wait_if(cy);
    join
    total++;
    if (sc !== c + 1) $display("FAIL fetch_stb_cycle: got %0d required %0d", sc, c + 1);
    else passed++;
    total++;
    if ({a, w, s} !== {32'h0000_0100, 1'b0, 4'hF})
      $display("FAIL fetch_fields: adr=%h we=%b sel=%h required 00000100/0/f", a, w, s);
    else passed++;
  endtask

  task automatic test_simultaneous();
    int c, sc0, sc1; logic [31:0] a0, d0, a1, d1; logic w0, w1, cy0, cy1; logic [3:0] s0, s1; bit h;
    @(negedge clk);
    c = cyc_cnt;
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h0000_8000; ls_sel = 4'b0011; ls_wdata = 32'h1234_5678;
    if_req = 1'b1; if_addr = 32'h0000_0104;
    sb.push_back(mk_exp(1'b1, 32'h0, 1'b0, c + 3));
    sb.push_back(mk_exp(1'b0, 32'h0BAD_F00D, 1'b0, c + 7));
    fork
      begin
        serve(0, 1, 32'h0, 1'b1, sc0, a0, w0, s0, d0, h);
        serve(0, 1, 32'h0BAD_F00D, 1'b1, sc1, a1, w1, s1, d1, h);
      end
      wait_ls(cy0);
      wait_if(cy1);
    join
    total++;
    if ({a0, w0, s0, d0} !== {32'h0000_8000, 1'b1, 4'b0011, 32'h1234_5678})
      $display("FAIL ls_write_fields: adr=%h we=%b sel=%h dat=%h required 00008000/1/3/12345678", a0, w0, s0, d0);
    else passed++;
    total++;
    if ({a1, w1, s1, sc1} !== {32'h0000_0104, 1'b0, 4'hF, c + 5})
      $display("FAIL if_second_grant: adr=%h we=%b sel=%h stb_cycle=%0d required 00000104/0/f/%0d", a1, w1, s1, sc1, c + 5);
    else passed++;
    ls_we = 1'b0;
  endtask

  task automatic test_fairness();
    int c, sc, n; logic [31:0] a, d; logic w; logic [3:0] s; bit h;
    logic [31:0] adr_seen [6];
    @(negedge clk);
    c = cyc_cnt;
    ls_req = 1'b1; ls_addr = 32'h0000_0300; ls_sel = 4'hF;
    if_req = 1'b1; if_addr = 32'h0000_0400;
    for (int k = 0; k < 6; k++)
      sb.push_back(mk_exp(k != 4, 32'hA0 + 32'(k), 1'b0, c + 3 + 4 * k));
    fork
      for (int k = 0; k < 6; k++) begin
        serve(0, 1, 32'hA0 + 32'(k), 1'b1, sc, a, w, s, d, h);
        adr_seen[k] = a;
      end
      begin
        n = 0;
        for (int j = 0; j < 80; j++) begin
          @(negedge clk);
          if (if_ack_o || ls_ack_o) n++;
          if (n == 6) break;
        end
        ls_req = 1'b0; if_req = 1'b0;
      end
    join
    for (int k = 0; k < 6; k++) begin
      total++;
      if (adr_seen[k] !== ((k == 4) ? 32'h0000_0400 : 32'h0000_0300))
        $display("FAIL fair_grant_%0d: adr=%h required %h", k, adr_seen[k], (k == 4) ? 32'h400 : 32'h300);
      else passed++;
    end
  endtask

  task automatic test_stall_and_fast_ack();
    int c, sc; logic [31:0] a, d; logic w, cy; logic [3:0] s; bit h;
    @(negedge clk);
    c = cyc_cnt; ls_req = 1'b1; ls_addr = 32'h0000_0200; ls_sel = 4'b1100;
    sb.push_back(mk_exp(1'b1, 32'hCAFE_F00D, 1'b0, c + 6));
    fork
      serve(3, 1, 32'hCAFE_F00D, 1'b1, sc, a, w, s, d, h);
      wait_ls(cy);
    join
    total++;
    if (h !== 1'b1 || a !== 32'h0000_0200) $display("FAIL stall_hold: held=%b adr=%h required 1/00000200", h, a);
    else passed++;
    @(negedge clk);
    c = cyc_cnt; if_req = 1'b1; if_addr = 32'h0000_0500;
    sb.push_back(mk_exp(1'b0, 32'h1122_3344, 1'b0, c + 2));
    fork
      serve(0, 0, 32'h1122_3344, 1'b1, sc, a, w, s, d, h);
      wait_if(cy);
    join
  endtask

  task automatic test_timeout();
    int c, sc; logic [31:0] a, d; logic w, cy; logic [3:0] s; bit h;
    @(negedge clk);
    c = cyc_cnt; ls_req = 1'b1; ls_addr = 32'h0000_0600;
    sb.push_back(mk_exp(1'b1, 32'h0, 1'b1, c + 10));
    fork
      serve(0, 0, 32'h0, 1'b0, sc, a, w, s, d, h);
      wait_ls(cy);
    join
    total++;
    if (cy !== 1'b0) $display("FAIL timeout_cyc_drop: cyc=%b at ack required 0", cy);
    else passed++;
    @(negedge clk);
    c = cyc_cnt; if_req = 1'b1; if_addr = 32'h0000_0700;
    sb.push_back(mk_exp(1'b0, 32'h7777_0001, 1'b0, c + 3));
    fork
      serve(0, 1, 32'h7777_0001, 1'b1, sc, a, w, s, d, h);
      wait_if(cy);
    join
  endtask

  task automatic test_reset_mid_wait();
    int c, sc, n; logic [31:0] a, d; logic w, cy; logic [3:0] s; bit h;
    @(negedge clk);
    ls_req = 1'b1; ls_addr = 32'h0000_0800;
    serve(0, 0, 32'h0, 1'b0, sc, a, w, s, d, h);
    @(negedge clk);
    total++;
    if ({wb_cyc_o, wb_stb_o} !== 2'b10) $display("FAIL wait_state: cyc/stb=%b%b required 10", wb_cyc_o, wb_stb_o);
    else passed++;
    #2 rst = 1'b1;
    #1;
    total++;
    if (outs !== '0) $display("FAIL async_reset: got %h required 0", outs);
    else passed++;
    ls_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    wb_ack_i = 1'b1; wb_dat_i = 32'hFFFF_FFFF;
    @(negedge clk);
    wb_ack_i = 1'b0; wb_dat_i = JUNK;
    n = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (if_ack_o || ls_ack_o || wb_cyc_o) n++;
    end
    total++;
    if (n !== 0) $display("FAIL stray_ack: %0d active cycles required 0", n);
    else passed++;
    c = cyc_cnt; if_req = 1'b1; if_addr = 32'h0000_0900;
    sb.push_back(mk_exp(1'b0, 32'h0900_0900, 1'b0, c + 3));
    fork
      serve(0, 1, 32'h0900_0900, 1'b1, sc, a, w, s, d, h);
      wait_if(cy);
    join
  endtask

  initial begin
    fork monitor(); join_none
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_fairness();
    test_stall_and_fast_ack();
    test_timeout();
    test_reset_mid_wait();
    repeat (3) @(negedge clk);
    total++;
    if (sb.size() != 0) $display("FAIL scoreboard_drain: %0d completions never seen, required 0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
